prog_loader: RTL

//  Serial program loader for the 8-bit CPU's 16x8 RAM. It receives a framed program over
//  a UART RX line (8N1, LSB first) and writes the bytes into RAM through a write port.
//  It holds the CPU in reset while loading, and releases it only after a checksum-verified load.
//  It sits between the board RX pin and the CPU's RAM write port / reset input.

---
 rtl/prog_loader.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// prog_loader: serial program loader for the 8-bit CPU's RAM.
// Receives a framed program over a UART RX line (8N1, LSB first):
//   0xA5 (sync), N (length), N data bytes, C (sum of data bytes mod 256)
// and writes the data bytes into RAM. The CPU is held in reset while a load is in
// progress and released only after a frame with a good checksum.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   i_rx         UART serial input, idles high, asynchronous to clk
//   o_ram_we     one-cycle RAM write strobe
//   o_ram_addr   RAM write address
//   o_ram_wdata  RAM write data
//   o_cpu_hold   high = CPU held in reset
//   o_busy       high while a frame is in progress
//   o_load_done  one-cycle pulse: frame loaded, checksum good
//   o_load_err   one-cycle pulse: frame aborted
module prog_loader #(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned TIMEOUT_CLKS = CLKS_PER_BIT * 40,
  parameter int unsigned RAM_DEPTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_rx,
  output logic                         o_ram_we,
  output logic [$clog2(RAM_DEPTH)-1:0] o_ram_addr,
  output logic [7:0]                   o_ram_wdata,
  output logic                         o_cpu_hold,
  output logic                         o_busy,
  output logic                         o_load_done,
  output logic                         o_load_err
);

  localparam int unsigned AW = $clog2(RAM_DEPTH);
  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam int unsigned TW = $clog2(TIMEOUT_CLKS + 1);

  // ---------------------------------------------------------------------------
  // RX synchroniser; r_rx_prev gives the falling-edge detector its history.
  // ---------------------------------------------------------------------------
  logic r_rx_meta, r_rx_sync, r_rx_prev;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_sync <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_rx_meta <= i_rx;
      r_rx_sync <= r_rx_meta;
      r_rx_prev <= r_rx_sync;
    end
  end

  // ---------------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       r_rx_state, w_rx_state_d;
  logic [CW-1:0]   r_clk_cnt, w_clk_cnt_d;
  logic [2:0]      r_bit_idx, w_bit_idx_d;
  logic [7:0]      r_shift, w_shift_d;
  logic            w_rx_valid;  // stop bit good: r_shift holds a byte this cycle
  logic            w_rx_ferr;   // stop bit low
  logic [7:0]      w_rx_byte;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_state <= RxIdle;
      r_clk_cnt  <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
    end else begin
      r_rx_state <= w_rx_state_d;
      r_clk_cnt  <= w_clk_cnt_d;
      r_bit_idx  <= w_bit_idx_d;
      r_shift    <= w_shift_d;
    end
  end

  always_comb begin
    w_rx_state_d = r_rx_state;
    w_clk_cnt_d  = r_clk_cnt + CW'(1);
    w_bit_idx_d  = r_bit_idx;
    w_shift_d    = r_shift;
    w_rx_valid   = 1'b0;
    w_rx_ferr    = 1'b0;
    unique case (r_rx_state)
      RxIdle: begin
        w_clk_cnt_d = '0;
        if (r_rx_prev && !r_rx_sync) w_rx_state_d = RxStart;
      end
      RxStart: begin
        // Mid start bit: a high level here means the edge was a glitch.
        if (r_clk_cnt == CW'(CLKS_PER_BIT / 2 - 1)) begin
          w_clk_cnt_d  = '0;
          w_bit_idx_d  = '0;
          w_rx_state_d = r_rx_sync ? RxIdle : RxData;
        end
      end
      RxData: begin
        if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_clk_cnt_d = '0;
          w_shift_d   = {r_rx_sync, r_shift[7:1]};
          w_bit_idx_d = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_rx_state_d = RxStop;
        end
      end
      RxStop: begin
        if (r_clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
          w_clk_cnt_d  = '0;
          w_rx_state_d = RxIdle;
          if (r_rx_sync) w_rx_valid = 1'b1;
          else           w_rx_ferr  = 1'b1;
        end
      end
      default: w_rx_state_d = RxIdle;
    endcase
  end

  assign w_rx_byte = r_shift;

  // ---------------------------------------------------------------------------
  // Frame loader FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {LdIdle, LdLen, LdData, LdCheck} ld_state_e;

  ld_state_e     r_ld_state, w_ld_state_d;
  logic [7:0]    r_len, w_len_d;
  logic [7:0]    r_idx, w_idx_d;
  logic [7:0]    r_sum, w_sum_d;
  logic [TW-1:0] r_to_cnt, w_to_cnt_d;
  logic          r_ram_we, w_ram_we_d;
  logic [AW-1:0] r_ram_addr, w_ram_addr_d;
  logic [7:0]    r_ram_wdata, w_ram_wdata_d;
  logic          r_cpu_hold, w_cpu_hold_d;
  logic          r_load_done, w_load_done_d;
  logic          r_load_err, w_load_err_d;
  logic          w_abort;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_state  <= LdIdle;
      r_len       <= '0;
      r_idx       <= '0;
      r_sum       <= '0;
      r_to_cnt    <= '0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_cpu_hold  <= 1'b0;
      r_load_done <= 1'b0;
      r_load_err  <= 1'b0;
    end else begin
      r_ld_state  <= w_ld_state_d;
      r_len       <= w_len_d;
      r_idx       <= w_idx_d;
      r_sum       <= w_sum_d;
      r_to_cnt    <= w_to_cnt_d;
      r_ram_we    <= w_ram_we_d;
      r_ram_addr  <= w_ram_addr_d;
      r_ram_wdata <= w_ram_wdata_d;
      r_cpu_hold  <= w_cpu_hold_d;
      r_load_done <= w_load_done_d;
      r_load_err  <= w_load_err_d;
    end
  end

  // Next state
  always_comb begin
    w_ld_state_d  = r_ld_state;
    w_len_d       = r_len;
    w_idx_d       = r_idx;
    w_sum_d       = r_sum;
    w_to_cnt_d    = r_to_cnt;
    w_ram_we_d    = 1'b0;
    w_ram_addr_d  = r_ram_addr;
    w_ram_wdata_d = r_ram_wdata;
    w_cpu_hold_d  = r_cpu_hold;
    w_load_done_d = 1'b0;
    w_load_err_d  = 1'b0;
    w_abort       = 1'b0;

    // Inter-byte timeout only runs inside a frame; a valid byte restarts it.
    if (r_ld_state == LdIdle || w_rx_valid) begin
      w_to_cnt_d = '0;
    end else if (r_to_cnt == TW'(TIMEOUT_CLKS - 1)) begin
      w_abort = 1'b1;
    end else begin
      w_to_cnt_d = r_to_cnt + TW'(1);
    end

    if (r_ld_state != LdIdle && w_rx_ferr) w_abort = 1'b1;

    unique case (r_ld_state)
      LdIdle: begin
        if (w_rx_valid && w_rx_byte == 8'hA5) w_ld_state_d = LdLen;
      end
      LdLen: begin
        if (w_rx_valid) begin
          if (w_rx_byte != 8'd0 && 32'(w_rx_byte) <= RAM_DEPTH) begin
            w_len_d      = w_rx_byte;
            w_idx_d      = '0;
            w_sum_d      = '0;
            w_cpu_hold_d = 1'b1;
            w_ld_state_d = LdData;
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      LdData: begin
        if (w_rx_valid) begin
          w_ram_we_d    = 1'b1;
          w_ram_addr_d  = r_idx[AW-1:0];
          w_ram_wdata_d = w_rx_byte;
          w_sum_d       = r_sum + w_rx_byte;
          w_idx_d       = r_idx + 8'd1;
          if (r_idx + 8'd1 == r_len) w_ld_state_d = LdCheck;
        end
      end
      LdCheck: begin
        if (w_rx_valid) begin
          if (w_rx_byte == r_sum) begin
            w_load_done_d = 1'b1;
            w_cpu_hold_d  = 1'b0;
            w_ld_state_d  = LdIdle;
          end else begin
            w_abort = 1'b1;
          end
        end
      end
      default: w_ld_state_d = LdIdle;
    endcase

    // Abort leaves cpu_hold alone so a partially written RAM is never released.
    if (w_abort) begin
      w_ld_state_d = LdIdle;
      w_load_err_d = 1'b1;
      w_to_cnt_d   = '0;
    end
  end

  // Outputs
  always_comb begin
    o_ram_we    = r_ram_we;
    o_ram_addr  = r_ram_addr;
    o_ram_wdata = r_ram_wdata;
    o_cpu_hold  = r_cpu_hold;
    o_busy      = (r_ld_state != LdIdle);
    o_load_done = r_load_done;
    o_load_err  = r_load_err;
  end

endmodule
